// File: rtl/clock_meter_pkg.sv
// Shared types and defaults for the clock period meter.
package clock_meter_pkg;
  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;
  localparam int DEFAULT_CNT_W = 28;
endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizes an asynchronous level into clock_in and emits registered
// one-cycle rise/fall strobes, SYNC_STAGES+1 cycles after the input edge.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock_in,
  input  logic reset_n,
  input  logic sig_in,
  output logic synced,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      last_q <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      last_q <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~last_q;
      fall   <= ~sync_q[SYNC_STAGES-1] & last_q;
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow asynchronous clock in clock_in
// cycles and flags lock once consecutive periods agree within TOL.
//
//   state | meaning
//   IDLE  | disabled, counters and lock cleared, results held
//   ARM   | waiting for the first rise to start a period
//   MEAS  | counting; each rise closes one period and starts the next
module clock_period_meter
  import clock_meter_pkg::*;
#(
  parameter int CNT_W       = DEFAULT_CNT_W,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4,
  parameter int TOL         = 0
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             meas_valid,
  output logic             locked,
  output logic             overflow
);

  localparam int               LC_W    = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [LC_W-1:0]  LC_MAX  = LC_W'(LOCK_COUNT);
  localparam logic [CNT_W:0]   TOL_V   = (CNT_W+1)'(TOL);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hi_hold;
  logic [LC_W-1:0]  lock_cnt;
  logic             have_prev;
  logic             rise;
  logic             fall;
  logic             unused_synced;
  logic [CNT_W:0]   diff;
  logic             period_match;
  logic             cnt_hits_max;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock_in (clock_in),
    .reset_n  (reset_n),
    .sig_in   (sig_in),
    .synced   (unused_synced),
    .rise     (rise),
    .fall     (fall)
  );

  // Extra bit keeps the magnitude exact for any pair of unsigned counts.
  always_comb begin
    diff = '0;
    if ({1'b0, cnt} >= {1'b0, period_out})
      diff = {1'b0, cnt} - {1'b0, period_out};
    else
      diff = {1'b0, period_out} - {1'b0, cnt};
  end

  assign period_match = (diff <= TOL_V);
  // True in the cycle whose increment lands on the saturation value.
  assign cnt_hits_max = (cnt >= CNT_MAX - CNT_W'(1));

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      hi_hold    <= '0;
      lock_cnt   <= '0;
      have_prev  <= 1'b0;
      period_out <= '0;
      high_out   <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (!enable) begin
        state     <= IDLE;
        cnt       <= '0;
        lock_cnt  <= '0;
        locked    <= 1'b0;
        overflow  <= 1'b0;
        have_prev <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= ARM;
          ARM: begin
            if (rise) begin
              cnt   <= CNT_W'(1);
              state <= MEAS;
            end
          end
          MEAS: begin
            locked <= (lock_cnt == LC_MAX);
            if (rise) begin
              cnt      <= CNT_W'(1);
              overflow <= 1'b0;
              // A period that touched saturation is discarded, even if it
              // ends exactly as the counter reaches the top.
              if (overflow || cnt_hits_max) begin
                lock_cnt <= '0;
                locked   <= 1'b0;
              end else begin
                period_out <= cnt;
                high_out   <= hi_hold;
                meas_valid <= 1'b1;
                have_prev  <= 1'b1;
                if (have_prev) begin
                  if (period_match) begin
                    if (lock_cnt != LC_MAX) lock_cnt <= lock_cnt + LC_W'(1);
                  end else begin
                    lock_cnt <= '0;
                    locked   <= 1'b0;
                  end
                end
              end
            end else begin
              if (fall) hi_hold <= cnt;
              if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
              if (cnt_hits_max) begin
                overflow <= 1'b1;
                lock_cnt <= '0;
                locked   <= 1'b0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter: three instances (TOL=0, TOL=2, CNT_W=8)
// share one stimulus so the tolerance and overflow variants are seen side by side.
module tb_clock_period_meter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic sig = 1'b0;

  logic [27:0] p0, h0, p1, h1;
  logic [7:0]  p2, h2;
  logic        mv0, l0, o0, mv1, l1, o1, mv2, l2, o2;

  int n_cmp = 0;
  int n_fail = 0;
  int mv0_cnt = 0;
  int mv2_cnt = 0;
  int div2_bad = 0;
  bit in_div2 = 1'b0;
  int snap;

  always #5 clk = ~clk;

  clock_period_meter #(.CNT_W(28), .SYNC_STAGES(2), .LOCK_COUNT(4), .TOL(0)) dut0 (
    .clock_in(clk), .reset_n(reset_n), .enable(enable), .sig_in(sig),
    .period_out(p0), .high_out(h0), .meas_valid(mv0), .locked(l0), .overflow(o0));

  clock_period_meter #(.CNT_W(28), .SYNC_STAGES(2), .LOCK_COUNT(4), .TOL(2)) dut1 (
    .clock_in(clk), .reset_n(reset_n), .enable(enable), .sig_in(sig),
    .period_out(p1), .high_out(h1), .meas_valid(mv1), .locked(l1), .overflow(o1));

  clock_period_meter #(.CNT_W(8), .SYNC_STAGES(2), .LOCK_COUNT(4), .TOL(0)) dut2 (
    .clock_in(clk), .reset_n(reset_n), .enable(enable), .sig_in(sig),
    .period_out(p2), .high_out(h2), .meas_valid(mv2), .locked(l2), .overflow(o2));

  always @(posedge clk) begin
    #1;
    if (mv0) begin
      mv0_cnt++;
      if (in_div2 && (p0 != 28'd2 || h0 != 28'd1)) div2_bad++;
    end
    if (mv2) mv2_cnt++;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic gen_period(input int hi, input int lo);
    sig = 1'b1;
    repeat (hi) @(negedge clk);
    sig = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    int hi; int lo; int reps;
    int d_mv; int p; int h; int lk0; int lk1;
  } row_t;

  row_t rows[7];

  initial begin
    // Each rise publishes the period that just ended, so expectations lag a row.
    rows[0] = '{5, 5, 5, 4, 10, 5, 0, 0};
    rows[1] = '{5, 5, 1, 1, 10, 5, 1, 1};
    rows[2] = '{6, 6, 1, 1, 10, 5, 1, 1};
    rows[3] = '{5, 5, 1, 1, 12, 6, 0, 1};
    rows[4] = '{5, 5, 1, 1, 10, 5, 0, 1};
    rows[5] = '{3, 7, 3, 3, 10, 3, 0, 1};
    rows[6] = '{3, 7, 1, 1, 10, 3, 1, 1};

    repeat (2) @(negedge clk);
    check("rst_period", p0, 0);
    check("rst_high", h0, 0);
    check("rst_valid", mv0, 0);
    check("rst_locked", l0, 0);
    check("rst_ovf", o0, 0);
    check("rst_period8", p2, 0);
    reset_n = 1'b1;
    enable = 1'b1;
    repeat (3) @(negedge clk);

    // Table: lock build-up, tolerance break, relock.
    for (int r = 0; r < 7; r++) begin
      snap = mv0_cnt;
      for (int k = 0; k < rows[r].reps; k++) gen_period(rows[r].hi, rows[r].lo);
      check($sformatf("row%0d_mv", r), mv0_cnt - snap, rows[r].d_mv);
      check($sformatf("row%0d_period", r), p0, rows[r].p);
      check($sformatf("row%0d_high", r), h0, rows[r].h);
      check($sformatf("row%0d_lock_tol0", r), l0, rows[r].lk0);
      check($sformatf("row%0d_lock_tol2", r), l1, rows[r].lk1);
      check($sformatf("row%0d_period8", r), p2, rows[r].p);
      check($sformatf("row%0d_lock8", r), l2, rows[r].lk0);
    end

    // Divide-by-2 input: minimum measurable period.
    do_reset();
    in_div2 = 1'b1;
    snap = mv0_cnt;
    repeat (20) gen_period(1, 1);
    repeat (6) @(negedge clk);
    in_div2 = 1'b0;
    check("div2_mv", mv0_cnt - snap, 19);
    check("div2_bad_values", div2_bad, 0);
    check("div2_period", p0, 2);
    check("div2_high", h0, 1);
    check("div2_locked", l0, 1);

    // Overflow on the 8-bit instance: sig_in stuck high 300 cycles.
    do_reset();
    repeat (7) gen_period(5, 5);
    check("ovf_pre_locked", l2, 1);
    sig = 1'b1;
    repeat (257) @(negedge clk);
    check("ovf_before_max", o2, 0);
    @(negedge clk);
    check("ovf_at_max", o2, 1);
    check("ovf_locked", l2, 0);
    check("ovf_period_held", p2, 10);
    snap = mv2_cnt;
    repeat (42) @(negedge clk);
    sig = 1'b0;
    repeat (5) @(negedge clk);
    gen_period(5, 5);
    check("ovf_rise_mv", mv2_cnt - snap, 0);
    check("ovf_cleared", o2, 0);
    check("wide_period", p0, 305);
    check("wide_high", h0, 300);
    gen_period(5, 5);
    check("ovf_after_mv", mv2_cnt - snap, 1);
    check("ovf_after_period", p2, 10);
    check("ovf_after_high", h2, 5);
    check("ovf_after_locked", l2, 0);

    // enable=0 mid-period, then re-enable during the low phase.
    do_reset();
    repeat (6) gen_period(5, 5);
    check("dis_pre_locked", l0, 1);
    snap = mv0_cnt;
    sig = 1'b1;
    repeat (2) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("dis_locked", l0, 0);
    check("dis_ovf", o0, 0);
    check("dis_period_held", p0, 10);
    check("dis_high_held", h0, 5);
    repeat (2) @(negedge clk);
    sig = 1'b0;
    repeat (5) @(negedge clk);
    gen_period(5, 5);
    check("dis_no_mv", mv0_cnt - snap, 0);
    sig = 1'b1;
    repeat (5) @(negedge clk);
    sig = 1'b0;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    repeat (3) @(negedge clk);
    gen_period(5, 5);
    check("reen_arm_mv", mv0_cnt - snap, 0);
    gen_period(5, 5);
    check("reen_first_mv", mv0_cnt - snap, 1);
    check("reen_period", p0, 10);
    check("reen_locked", l0, 0);

    // Async reset mid-period.
    do_reset();
    repeat (6) gen_period(5, 5);
    check("rstmid_pre_locked", l0, 1);
    sig = 1'b1;
    repeat (5) @(negedge clk);
    sig = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("rstmid_period", p0, 0);
    check("rstmid_high", h0, 0);
    check("rstmid_locked", l0, 0);
    check("rstmid_ovf", o0, 0);
    check("rstmid_valid", mv0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    snap = mv0_cnt;
    gen_period(5, 5);
    check("rstmid_arm_mv", mv0_cnt - snap, 0);
    gen_period(5, 5);
    check("rstmid_first_mv", mv0_cnt - snap, 1);
    check("rstmid_new_period", p0, 10);
    check("rstmid_new_high", h0, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
